// File: rtl/usr_burst_if.sv
// Handshake/data bundle for the usr_burst universal shift register.
// The master drives the controls and the slave (the register) drives the results.
interface usr_burst_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] ip;
  logic             leftS;
  logic             rightS;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output en, sel, ip, leftS, rightS, start, amount,
    input  q, qb, sout_l, sout_r, busy, done
  );

  modport slave (
    input  en, sel, ip, leftS, rightS, start, amount,
    output q, qb, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/usr_burst.sv
// Universal shift register with hold/shift/rotate/asr/load/clear modes and a
// multi-cycle burst shift (busy/done handshake) of a latched shift-class mode.
module usr_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic        clk,
  input logic        rst,
  usr_burst_if.slave bus
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e           state_q;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] qb_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] q_d;
  logic             accept;

  function automatic logic shift_class(input logic [2:0] m);
    return (m != 3'b000) && (m != 3'b011) && (m != 3'b111);
  endfunction

  function automatic logic [WIDTH-1:0] step_fn(input logic [2:0]       m,
                                               input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] ld,
                                               input logic             ls,
                                               input logic             rs);
    logic [WIDTH-1:0] r;
    case (m)
      3'b001:  r = {rs, v[WIDTH-1:1]};
      3'b010:  r = {v[WIDTH-2:0], ls};
      3'b011:  r = ld;
      3'b100:  r = {v[0], v[WIDTH-1:1]};
      3'b101:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b110:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      3'b111:  r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    step_mode = (state_q == StBurst) ? mode_q : bus.sel;
    step_val  = step_fn(step_mode, q_q, bus.ip, bus.leftS, bus.rightS);
    accept    = (state_q == StIdle) && bus.en && bus.start && shift_class(bus.sel);
    q_d       = q_q;
    // The acceptance edge only latches the burst; it does not step.
    if (bus.en && !accept) begin
      q_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 3'b000;
      cnt_q   <= '0;
      q_q     <= '0;
      qb_q    <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      qb_q   <= ~q_d;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            mode_q <= bus.sel;
            if (bus.amount == '0) begin
              done_q <= 1'b1;
            end else begin
              cnt_q   <= bus.amount;
              busy_q  <= 1'b1;
              state_q <= StBurst;
            end
          end
        end
        StBurst: begin
          if (bus.en) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.q      = q_q;
  assign bus.qb     = qb_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_usr_burst.sv
// Directed self-checking bench for usr_burst: single steps, bursts, stalls,
// zero/oversized amounts, mid-burst reset and back-to-back bursts.
module tb_usr_burst;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  usr_burst_if #(.WIDTH(8), .CNT_W(8)) bus ();

  usr_burst #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    bus.sel = 3'b011;
    bus.ip  = v;
    tick();
    bus.sel = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load(8'hA5);
    checks++;
    if (bus.q !== 8'hA5) begin
      errors++;
      $display("FAIL preload q got %h want a5", bus.q);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.q !== 8'h00) begin
      errors++;
      $display("FAIL reset q got %h want 00", bus.q);
    end
    checks++;
    if (bus.qb !== 8'hFF) begin
      errors++;
      $display("FAIL reset qb got %h want ff", bus.qb);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset busy/done got %b%b want 00", bus.busy, bus.done);
    end
  endtask

  task automatic test_single_steps();
    logic [2:0] sels [5] = '{3'b011, 3'b001, 3'b010, 3'b110, 3'b111};
    logic [7:0] exps [5] = '{8'h96, 8'hCB, 8'h96, 8'hCB, 8'h00};
    bus.ip     = 8'h96;
    bus.rightS = 1'b1;
    bus.leftS  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sel = sels[i];
      tick();
      checks++;
      if (bus.q !== exps[i] || bus.qb !== ~exps[i]) begin
        errors++;
        $display("FAIL step%0d q/qb got %h/%h want %h/%h", i, bus.q, bus.qb, exps[i], ~exps[i]);
      end
      if (i == 0) begin
        checks++;
        if (bus.sout_l !== 1'b1 || bus.sout_r !== 1'b0) begin
          errors++;
          $display("FAIL sout got l=%b r=%b want l=1 r=0", bus.sout_l, bus.sout_r);
        end
      end
    end
    bus.sel = 3'b000;
  endtask

  task automatic test_rotate_burst();
    logic [7:0] exps [3] = '{8'h03, 8'h06, 8'h0C};
    load(8'h81);
    bus.sel    = 3'b101;
    bus.amount = 8'd3;
    bus.start  = 1'b1;
    tick();
    bus.sel = 3'b000;
    checks++;
    if (bus.busy !== 1'b1 || bus.q !== 8'h81 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rot accept got busy=%b q=%h done=%b want 1 81 0", bus.busy, bus.q, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      bus.start = (i == 1);  // stray start mid-burst must be ignored
      tick();
      checks++;
      if (bus.q !== exps[i] || bus.busy !== (i < 2) || bus.done !== (i == 2)) begin
        errors++;
        $display("FAIL rot edge%0d got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i + 1, bus.q, bus.busy, bus.done, exps[i], i < 2, i == 2);
      end
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.q !== 8'h0C) begin
      errors++;
      $display("FAIL rot after got done=%b q=%h want 0 0c", bus.done, bus.q);
    end
  endtask

  task automatic test_burst_stall();
    int busy_cnt = 0;
    int done_cnt = 0;
    load(8'hF0);
    bus.sel    = 3'b001;
    bus.rightS = 1'b0;
    bus.amount = 8'd4;
    bus.start  = 1'b1;
    tick();
    bus.sel   = 3'b000;
    bus.start = 1'b0;
    if (bus.busy === 1'b1) busy_cnt++;
    for (int i = 0; i < 10; i++) begin
      bus.en = !(i == 1 || i == 2);
      tick();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
    bus.en = 1'b1;
    checks++;
    if (busy_cnt != 6) begin
      errors++;
      $display("FAIL stall busy cycles got %0d want 6", busy_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL stall done pulses got %0d want 1", done_cnt);
    end
    checks++;
    if (bus.q !== 8'h0F) begin
      errors++;
      $display("FAIL stall q got %h want 0f", bus.q);
    end
  endtask

  task automatic test_amount_zero();
    load(8'h5A);
    bus.sel    = 3'b001;
    bus.amount = 8'd0;
    bus.start  = 1'b1;
    tick();
    bus.sel   = 3'b000;
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 8'h5A) begin
      errors++;
      $display("FAIL amt0 got done=%b busy=%b q=%h want 1 0 5a", bus.done, bus.busy, bus.q);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL amt0 after got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_amount_wrap();
    int edges = 0;
    load(8'h01);
    bus.sel    = 3'b100;
    bus.amount = 8'd10;
    bus.start  = 1'b1;
    tick();
    bus.sel   = 3'b000;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != 10) begin
      errors++;
      $display("FAIL wrap edges to done got %0d want 10", edges);
    end
    checks++;
    if (bus.q !== 8'h40) begin
      errors++;
      $display("FAIL wrap q got %h want 40", bus.q);
    end
  endtask

  task automatic test_mid_reset();
    int edges = 0;
    load(8'h01);
    bus.sel    = 3'b010;
    bus.leftS  = 1'b1;
    bus.amount = 8'd5;
    bus.start  = 1'b1;
    tick();
    bus.sel   = 3'b000;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.q !== 8'h03) begin
      errors++;
      $display("FAIL midrst step1 q got %h want 03", bus.q);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.q !== 8'h00 || bus.qb !== 8'hFF || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst got q=%h qb=%h busy=%b done=%b want 00 ff 0 0",
               bus.q, bus.qb, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
      errors++;
      $display("FAIL midrst after got done=%b busy=%b q=%h want 0 0 00", bus.done, bus.busy, bus.q);
    end
    bus.sel    = 3'b010;
    bus.amount = 8'd2;
    bus.start  = 1'b1;
    tick();
    bus.sel   = 3'b000;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && edges < 10) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != 2 || bus.q !== 8'h03) begin
      errors++;
      $display("FAIL midrst reburst got edges=%0d q=%h want 2 03", edges, bus.q);
    end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    bus.sel    = 3'b101;
    bus.amount = 8'd1;
    bus.start  = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.q !== 8'h02 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b first got q=%h done=%b busy=%b want 02 1 0", bus.q, bus.done, bus.busy);
    end
    tick();
    bus.start = 1'b0;
    bus.sel   = 3'b000;
    checks++;
    if (bus.q !== 8'h02 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b reaccept got q=%h busy=%b done=%b want 02 1 0", bus.q, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.q !== 8'h04 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b second got q=%h done=%b busy=%b want 04 1 0", bus.q, bus.done, bus.busy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.en     = 1'b1;
    bus.sel    = 3'b000;
    bus.ip     = '0;
    bus.leftS  = 1'b0;
    bus.rightS = 1'b0;
    bus.start  = 1'b0;
    bus.amount = '0;
    tick();
    test_reset();
    test_single_steps();
    test_rotate_burst();
    test_burst_stall();
    test_amount_zero();
    test_amount_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
